carry_lookahead_adder_16bit: RTL and testbench



---
 rtl/carry_lookahead_adder_16bit.sv | 98 +++++++++
 tb/tb_carry_lookahead_adder_16bit.sv | 137 +++++++++++++
 2 files changed

// File: rtl/carry_lookahead_adder_16bit.sv
// Registered 16-bit two-level carry-lookahead adder.
// Sum and carry-out of inData_A + inData_B + cin appear one clock after the
// operands are sampled. Four 4-bit lookahead groups feed a second-level unit
// that resolves the group carry-ins, so no carry ever ripples bit by bit.
module carry_lookahead_adder_16bit #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2*DATA_WIDTH-1:0]   inData_A,
  input  logic [2*DATA_WIDTH-1:0]   inData_B,
  input  logic                      cin,
  output logic [2*DATA_WIDTH-1:0]   outData,
  output logic                      cout
);

  // Bit-level generate/propagate, per-bit carries and sum bits.
  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [15:0] w_c;
  logic [15:0] w_sum;

  // Group-level generate/propagate and group carry-ins (w_gc[4] is C16).
  logic [3:0]  w_grp_g;
  logic [3:0]  w_grp_p;
  logic [4:0]  w_gc;

  logic [15:0] r_sum;
  logic        r_cout;

  assign w_g = inData_A & inData_B;
  assign w_p = inData_A ^ inData_B;

  // Each group computes its own G/P for the second level and expands its
  // group carry-in into the three internal carries without rippling.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_group
      logic [3:0] w_lg;
      logic [3:0] w_lp;
      logic       w_ci;

      assign w_lg = w_g[4*gi +: 4];
      assign w_lp = w_p[4*gi +: 4];
      assign w_ci = w_gc[gi];

      assign w_grp_p[gi] = w_lp[3] & w_lp[2] & w_lp[1] & w_lp[0];
      assign w_grp_g[gi] = w_lg[3]
                         | (w_lp[3] & w_lg[2])
                         | (w_lp[3] & w_lp[2] & w_lg[1])
                         | (w_lp[3] & w_lp[2] & w_lp[1] & w_lg[0]);

      assign w_c[4*gi]     = w_ci;
      assign w_c[4*gi + 1] = w_lg[0]
                           | (w_lp[0] & w_ci);
      assign w_c[4*gi + 2] = w_lg[1]
                           | (w_lp[1] & w_lg[0])
                           | (w_lp[1] & w_lp[0] & w_ci);
      assign w_c[4*gi + 3] = w_lg[2]
                           | (w_lp[2] & w_lg[1])
                           | (w_lp[2] & w_lp[1] & w_lg[0])
                           | (w_lp[2] & w_lp[1] & w_lp[0] & w_ci);
    end
  endgenerate

  // Second-level lookahead: group carry-ins straight from (G, P, cin).
  assign w_gc[0] = cin;
  assign w_gc[1] = w_grp_g[0]
                 | (w_grp_p[0] & cin);
  assign w_gc[2] = w_grp_g[1]
                 | (w_grp_p[1] & w_grp_g[0])
                 | (w_grp_p[1] & w_grp_p[0] & cin);
  assign w_gc[3] = w_grp_g[2]
                 | (w_grp_p[2] & w_grp_g[1])
                 | (w_grp_p[2] & w_grp_p[1] & w_grp_g[0])
                 | (w_grp_p[2] & w_grp_p[1] & w_grp_p[0] & cin);
  assign w_gc[4] = w_grp_g[3]
                 | (w_grp_p[3] & w_grp_g[2])
                 | (w_grp_p[3] & w_grp_p[2] & w_grp_g[1])
                 | (w_grp_p[3] & w_grp_p[2] & w_grp_p[1] & w_grp_g[0])
                 | (w_grp_p[3] & w_grp_p[2] & w_grp_p[1] & w_grp_p[0] & cin);

  assign w_sum = w_p ^ w_c;

  // Output register; reset clears the result and wins over new operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum  <= 16'h0000;
      r_cout <= 1'b0;
    end else begin
      r_sum  <= w_sum;
      r_cout <= w_gc[4];
    end
  end

  assign outData = r_sum;
  assign cout    = r_cout;

endmodule

// File: tb/tb_carry_lookahead_adder_16bit.sv
// Self-checking bench for carry_lookahead_adder_16bit: directed corner cases,
// back-to-back random stream and mid-stream reset, checked against plain
// 17-bit arithmetic.
module tb_carry_lookahead_adder_16bit;

  logic        clk;
  logic        rst;
  logic [15:0] inData_A;
  logic [15:0] inData_B;
  logic        cin;
  logic [15:0] outData;
  logic        cout;

  int n_tests;
  int n_fail;

  carry_lookahead_adder_16bit #(.DATA_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .inData_A (inData_A),
    .inData_B (inData_B),
    .cin      (cin),
    .outData  (outData),
    .cout     (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full-precision unsigned add, or zero when reset is applied.
  function automatic logic [16:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic c, input logic r);
    int unsigned total;
    total = int'(a) + int'(b) + int'(c);
    return r ? 17'd0 : total[16:0];
  endfunction

  // Drive one vector, clock it in, and compare one time unit after the edge.
  task automatic step(input logic [15:0] a, input logic [15:0] b, input logic c,
                      input logic r, input string tag);
    logic [16:0] exp;
    inData_A = a;
    inData_B = b;
    cin      = c;
    rst      = r;
    exp      = ref_model(a, b, c, r);
    @(posedge clk);
    #1;
    n_tests++;
    $display("[TB] %s rst=%0b A=%04h B=%04h cin=%0b -> cout=%0b sum=%04h (exp cout=%0b sum=%04h)",
             tag, r, a, b, c, cout, outData, exp[16], exp[15:0]);
    assert ({cout, outData} === exp) else begin
      n_fail++;
      $error("FAIL %s: got cout=%0b sum=%04h, expected cout=%0b sum=%04h",
             tag, cout, outData, exp[16], exp[15:0]);
    end
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic [16:0] held;
    n_tests = 0;
    n_fail  = 0;

    // Reset holds outputs at zero regardless of operands.
    step(16'hFFFF, 16'h0001, 1'b1, 1'b1, "reset_edge1");
    step(16'hFFFF, 16'h0001, 1'b1, 1'b1, "reset_edge2");
    step(16'hFFFF, 16'h0001, 1'b1, 1'b0, "reset_release");

    // Basic adds.
    step(16'h1234, 16'h4321, 1'b0, 1'b0, "basic_cin0");
    step(16'h1234, 16'h4321, 1'b1, 1'b0, "basic_cin1");

    // Full propagate chains.
    step(16'hFFFF, 16'h0000, 1'b1, 1'b0, "prop_chain_cin");
    step(16'hFFFF, 16'h0001, 1'b0, 1'b0, "prop_chain_b1");

    // Group boundaries and maximum case.
    step(16'h000F, 16'h0001, 1'b0, 1'b0, "grp_boundary_4");
    step(16'h00FF, 16'h0001, 1'b0, 1'b0, "grp_boundary_8");
    step(16'h0FFF, 16'h0001, 1'b0, 1'b0, "grp_boundary_12");
    step(16'h8000, 16'h8000, 1'b0, 1'b0, "msb_overflow");
    step(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "max_case");
    step(16'h0000, 16'h0000, 1'b0, 1'b0, "zero_case");

    // Outputs must ignore input changes between edges.
    held = ref_model(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    step(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "hold_load");
    inData_A = 16'h0001;
    inData_B = 16'h0002;
    cin      = 1'b0;
    #3;
    n_tests++;
    assert ({cout, outData} === held) else begin
      n_fail++;
      $error("FAIL hold_between_edges: got cout=%0b sum=%04h, expected cout=%0b sum=%04h",
             cout, outData, held[16], held[15:0]);
    end

    // Back-to-back random stream, one vector per clock.
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom_range(16'hFFFE, 0));
      rb = 16'($urandom_range(16'hFFFE, 0));
      rc = 1'($urandom_range(1, 0));
      step(ra, rb, rc, 1'b0, "stream");
    end

    // Reset for one edge in the middle of a stream.
    for (int i = 0; i < 3; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(1, 0));
      step(ra, rb, rc, 1'b0, "pre_reset");
      ra = 16'($urandom);
      rb = 16'($urandom);
      step(ra, rb, 1'b1, 1'b1, "mid_reset");
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(1, 0));
      step(ra, rb, rc, 1'b0, "post_reset");
    end

    // Full-range random operands.
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(1, 0));
      step(ra, rb, rc, 1'b0, "full_range");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
